inst_buffer: RTL and testbench
==============================

# inst_buffer

Two-wide instruction FIFO between the IF3 output register and decode. Each cycle it accepts up to two instructions from fetch and presents up to two of the oldest buffered instructions to decode. It asserts a pause request upstream when it cannot guarantee space for two more, and it supports a one-cycle flush on redirect.

## Interface
- `DEPTH`, 16: number of entries; a power of two, at least 4.
- `DATA_W`, 64: width of one entry payload ({pc[31:0], inst[31:0]} by default).
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous clear of all entries; takes priority over push and pop.
- `in0_valid`, `in1_valid` input 1 each: fetch slot valid bits, older slot first.
- `in0_data`, `in1_data` input DATA_W each: fetch slot payloads.
- `pause_req` output 1: high when the number of free entries is below 2; fetch holds its output register while this is high.
- `out0_valid`, `out1_valid` output 1 each: head and head+1 entry present.
- `out0_data`, `out1_data` output DATA_W each: head and head+1 payloads.
- `out0_ready`, `out1_ready` input 1 each: decode accepts the slot this cycle.
- `count` output $clog2(DEPTH)+1: number of occupied entries.

## Operation
- Storage is a circular array of DEPTH entries with `head` and `tail` pointers of $clog2(DEPTH) bits. Both wrap modulo DEPTH. `count` is held separately so full and empty are distinguishable.
- Push is enabled when `pause_req`=0 and `flush`=0. The number of writes is the popcount of in0_valid and in1_valid (0..2).
  - Both valid: in0 goes to tail and in1 to tail+1.
  - Only in1 valid: it is compacted into tail.
  - Only in0 valid: it goes to tail.
  - tail advances by the number of writes.
- When `pause_req`=1, input valids are ignored and nothing is written. Fetch keeps presenting the same pair.
- Pop count:
  - pop0 = out0_valid & out0_ready.
  - pop1 = pop0 & out1_valid & out1_ready. Slot 1 is never consumed unless slot 0 is consumed in the same cycle.
  - head advances by pop0+pop1.
- Output valids:
  - out0_valid = (count≥1).
  - out1_valid = (count≥2).
  - out*_data are read combinationally from head and head+1 (mod DEPTH). Data is don't-care when the matching valid is low.
- Next count = count + pushes − pops. Push and pop may occur in the same cycle.
- `pause_req` = (DEPTH − count < 2), decoded combinationally from the registered count.
- `flush`=1: head, tail and count become 0 at the edge. Inputs and readies are ignored in that cycle.
- Overflow is impossible by construction. Any assertion of count>DEPTH is a design bug.

## Timing
- Reset values (asynchronous, while rst=0): head=0, tail=0, count=0, out0_valid=0, out1_valid=0, pause_req=0. Storage contents are not reset.
- Fill latency is 1 cycle: a pair pushed at edge N is visible on out0/out1 after edge N. There is no same-cycle input-to-output bypass.
- Pop takes effect at the edge. The next entries appear after that edge.
- `pause_req` reflects the count after the current edge. Its effect on fetch is therefore registered, with no combinational path from inputs.
- Full (count=DEPTH): pause_req=1, pops still allowed. A pop brings the free count back to ≥2 only after the edge.
- count=DEPTH−1: pause_req=1 even though one slot is free. This is intentional because push is all-or-nothing.
- Empty: both out valids are low and readies are ignored. A simultaneous push is visible next cycle.
- Wrap: a pair written at tail=DEPTH−1 lands in entries DEPTH−1 and 0. A read at head=DEPTH−1 returns entries DEPTH−1 and 0.
- flush together with reset: reset dominates.
- rst asserted mid-operation clears state immediately, without waiting for a clock edge.

## Test plan
- Reset, then push {A,B}, {C,D} on consecutive cycles with readies low. Required: count goes 2→4, out0=A, out1=B, pause_req=0.
- In the same state, set out0_ready=1 and out1_ready=0 for one cycle. Required: count=3, out0=B, out1=C. Then set out0_ready=0 and out1_ready=1. Required: no pop.
- Single-valid push: in0_valid=0, in1_valid=1 with data E into an empty buffer. Required: count=1, out0=E, out1_valid=0.
- Fill with DEPTH=16 by pushing 8 pairs with no pops. Required: count=16, pause_req=1.
  - Push further pairs: ignored, count stays 16.
  - Pop 1: count=15, pause_req still 1.
  - Pop 1 more: count=14, pause_req=0.
- Wrap: run continuous push 2 / pop 2 for 20 cycles. Required: output order equals input order across the head/tail wrap, and count stays constant.
- Flush with count=6 while pushing a pair and popping 2. Required: count=0 and both valids low next cycle. Assert rst low mid-stream. Required: outputs clear without a clock edge.

Source files
------------

// File: rtl/inst_buffer_if.sv
// Fetch/decode handshake bundle for the two-wide instruction buffer.
// The buffer connects through the slave modport; the driver of fetch slots
// and decode readies (fetch + decode side) uses the master modport.
interface inst_buffer_if #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 16
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              flush;
   logic              in0_valid;
   logic              in1_valid;
   logic [DATA_W-1:0] in0_data;
   logic [DATA_W-1:0] in1_data;
   logic              pause_req;
   logic              out0_valid;
   logic              out1_valid;
   logic [DATA_W-1:0] out0_data;
   logic [DATA_W-1:0] out1_data;
   logic              out0_ready;
   logic              out1_ready;
   logic [CNT_W-1:0]  count;

   modport slave (
      input  flush, in0_valid, in1_valid, in0_data, in1_data,
      input  out0_ready, out1_ready,
      output pause_req, out0_valid, out1_valid, out0_data, out1_data, count
   );

   modport master (
      output flush, in0_valid, in1_valid, in0_data, in1_data,
      output out0_ready, out1_ready,
      input  pause_req, out0_valid, out1_valid, out0_data, out1_data, count
   );
endinterface

// File: rtl/inst_buffer.sv
// Two-wide instruction FIFO between the fetch output register and decode.
// Accepts 0..2 instructions per cycle (all-or-nothing against free space),
// presents the two oldest entries, and clears on a one-cycle flush.
module inst_buffer #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 64
) (
   input  logic         clk,
   input  logic         rst,
   inst_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [PTR_W-1:0]  head_nxt1;
   logic [PTR_W-1:0]  tail_nxt1;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  free;
   logic              pause;
   logic              vld0;
   logic              vld1;
   logic              push_en;
   logic              pop0;
   logic              pop1;
   logic [1:0]        n_push;
   logic [1:0]        n_pop;

   // Occupancy decode, read ports and push/pop amounts for this cycle
   always_comb begin
      free      = CNT_W'(DEPTH) - count_r;
      // One free slot still pauses: a pair can never be split across cycles.
      pause     = (free < CNT_W'(2));
      vld0      = (count_r != '0);
      vld1      = (count_r >= CNT_W'(2));
      head_nxt1 = head + PTR_W'(1);
      tail_nxt1 = tail + PTR_W'(1);
      push_en   = !pause && !bus.flush;
      n_push    = push_en ? ({1'b0, bus.in0_valid} + {1'b0, bus.in1_valid}) : 2'd0;
      // Slot 1 is only consumed together with slot 0 so order is preserved.
      pop0      = vld0 && bus.out0_ready && !bus.flush;
      pop1      = pop0 && vld1 && bus.out1_ready;
      n_pop     = {1'b0, pop0} + {1'b0, pop1};
   end

   assign bus.pause_req  = pause;
   assign bus.out0_valid = vld0;
   assign bus.out1_valid = vld1;
   assign bus.out0_data  = mem[head];
   assign bus.out1_data  = mem[head_nxt1];
   assign bus.count      = count_r;

   // Pointer and occupancy state; flush clears everything, reset dominates
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head    <= '0;
         tail    <= '0;
         count_r <= '0;
      end else if (bus.flush) begin
         head    <= '0;
         tail    <= '0;
         count_r <= '0;
      end else begin
         head    <= head + PTR_W'(n_pop);
         tail    <= tail + PTR_W'(n_push);
         count_r <= count_r + CNT_W'(n_push) - CNT_W'(n_pop);
      end
   end

   // Payload storage; a lone in1 is compacted into the tail slot
   always_ff @(posedge clk) begin
      if (push_en) begin
         if (bus.in0_valid) begin
            mem[tail] <= bus.in0_data;
         end else if (bus.in1_valid) begin
            mem[tail] <= bus.in1_data;
         end
         if (bus.in0_valid && bus.in1_valid) begin
            mem[tail_nxt1] <= bus.in1_data;
         end
      end
   end

   // Occupancy can never exceed capacity; anything else is a logic bug
   count_in_range : assert property (@(posedge clk) disable iff (!rst)
      count_r <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: a queue model records every accepted
// instruction, a negedge monitor compares the presented slots against it,
// and directed steps check hand-computed counts and payloads.
module tb_inst_buffer;
   localparam int DEPTH  = 16;
   localparam int DATA_W = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   mon_en = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [DATA_W-1:0] exp_q[$];

   inst_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus();

   inst_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit v0, input logic [63:0] d0, input bit v1,
                        input logic [63:0] d1, input bit r0, input bit r1, input bit fl);
      bus.in0_valid  = v0;
      bus.in0_data   = d0;
      bus.in1_valid  = v1;
      bus.in1_data   = d1;
      bus.out0_ready = r0;
      bus.out1_ready = r1;
      bus.flush      = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard feed: record accepted instructions, retire consumed ones
   always @(posedge clk or negedge rst) begin
      int sz;
      bit p0;
      bit p1;
      if (!rst) begin
         exp_q.delete();
      end else if (bus.flush) begin
         exp_q.delete();
      end else begin
         sz = exp_q.size();
         p0 = (sz >= 1) && bus.out0_ready;
         p1 = p0 && (sz >= 2) && bus.out1_ready;
         if (p0) void'(exp_q.pop_front());
         if (p1) void'(exp_q.pop_front());
         if (DEPTH - sz >= 2) begin
            if (bus.in0_valid) exp_q.push_back(bus.in0_data);
            if (bus.in1_valid) exp_q.push_back(bus.in1_data);
         end
      end
   end

   // Monitor: compare whatever the buffer presents with the oldest expected entries
   always @(negedge clk) begin
      if (rst && mon_en) begin
         chk("mon_count", 64'(bus.count), 64'(exp_q.size()));
         chk("mon_out0_valid", 64'(bus.out0_valid), 64'(exp_q.size() >= 1));
         chk("mon_out1_valid", 64'(bus.out1_valid), 64'(exp_q.size() >= 2));
         chk("mon_pause_req", 64'(bus.pause_req), 64'((DEPTH - exp_q.size()) < 2));
         if (exp_q.size() >= 1) chk("mon_out0_data", bus.out0_data, exp_q[0]);
         if (exp_q.size() >= 2) chk("mon_out1_data", bus.out1_data, exp_q[1]);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(0, '0, 0, '0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_out0_valid", 64'(bus.out0_valid), 64'd0);
      chk("rst_out1_valid", 64'(bus.out1_valid), 64'd0);
      chk("rst_pause_req", 64'(bus.pause_req), 64'd0);
      rst    = 1'b1;
      mon_en = 1'b1;

      // Two pairs, no pops
      drive(1, 64'hA, 1, 64'hB, 0, 0, 0);
      step();
      chk("pairAB_count", 64'(bus.count), 64'd2);
      chk("pairAB_out0", bus.out0_data, 64'hA);
      chk("pairAB_out1", bus.out1_data, 64'hB);
      drive(1, 64'hC, 1, 64'hD, 0, 0, 0);
      step();
      chk("pairCD_count", 64'(bus.count), 64'd4);
      chk("pairCD_out0", bus.out0_data, 64'hA);
      chk("pairCD_out1", bus.out1_data, 64'hB);
      chk("pairCD_pause", 64'(bus.pause_req), 64'd0);

      // Pop slot 0 only, then slot 1 alone must not pop
      drive(0, '0, 0, '0, 1, 0, 0);
      step();
      chk("pop0_count", 64'(bus.count), 64'd3);
      chk("pop0_out0", bus.out0_data, 64'hB);
      chk("pop0_out1", bus.out1_data, 64'hC);
      drive(0, '0, 0, '0, 0, 1, 0);
      step();
      chk("pop1only_count", 64'(bus.count), 64'd3);
      chk("pop1only_out0", bus.out0_data, 64'hB);

      // Drain 3 -> 1 -> 0
      drive(0, '0, 0, '0, 1, 1, 0);
      step();
      step();
      chk("drain_count", 64'(bus.count), 64'd0);
      chk("drain_out0_valid", 64'(bus.out0_valid), 64'd0);

      // Lone in1 is compacted into the tail
      drive(0, '0, 1, 64'hE, 0, 0, 0);
      step();
      chk("in1only_count", 64'(bus.count), 64'd1);
      chk("in1only_out0", bus.out0_data, 64'hE);
      chk("in1only_out1_valid", 64'(bus.out1_valid), 64'd0);
      drive(0, '0, 0, '0, 1, 0, 0);
      step();
      // Lone in0 into empty buffer with readies high (readies ignored when empty)
      drive(1, 64'hF, 0, '0, 1, 1, 0);
      step();
      chk("in0only_count", 64'(bus.count), 64'd1);
      chk("in0only_out0", bus.out0_data, 64'hF);
      drive(0, '0, 0, '0, 1, 1, 0);
      step();

      // Fill with 8 pairs
      for (int i = 0; i < 8; i++) begin
         drive(1, 64'h100 + 64'(2 * i), 1, 64'h101 + 64'(2 * i), 0, 0, 0);
         step();
         chk("fill_count", 64'(bus.count), 64'(2 * (i + 1)));
         chk("fill_pause", 64'(bus.pause_req), 64'(i == 7));
      end
      drive(1, 64'hDEAD, 1, 64'hBEEF, 0, 0, 0);
      step();
      chk("full_ignore_count", 64'(bus.count), 64'd16);
      chk("full_out0", bus.out0_data, 64'h100);
      drive(1, 64'hDEAD, 1, 64'hBEEF, 1, 0, 0);
      step();
      chk("full_pop1_count", 64'(bus.count), 64'd15);
      chk("full_pop1_pause", 64'(bus.pause_req), 64'd1);
      chk("full_pop1_out0", bus.out0_data, 64'h101);
      step();
      chk("full_pop2_count", 64'(bus.count), 64'd14);
      chk("full_pop2_pause", 64'(bus.pause_req), 64'd0);
      chk("full_pop2_out0", bus.out0_data, 64'h102);
      drive(0, '0, 0, '0, 1, 1, 0);
      repeat (7) step();
      chk("full_drain_count", 64'(bus.count), 64'd0);

      // Set up an odd head so both pointers cross DEPTH-1 during streaming
      drive(1, 64'h9, 0, '0, 0, 0, 0);
      step();
      drive(1, 64'h10, 1, 64'h11, 0, 0, 0);
      step();
      drive(0, '0, 0, '0, 1, 0, 0);
      step();
      chk("wrap_prep_count", 64'(bus.count), 64'd2);
      chk("wrap_prep_out0", bus.out0_data, 64'h10);
      chk("wrap_prep_out1", bus.out1_data, 64'h11);
      for (int i = 0; i < 20; i++) begin
         drive(1, 64'h2000 + 64'(2 * i), 1, 64'h2001 + 64'(2 * i), 1, 1, 0);
         step();
         chk("wrap_count", 64'(bus.count), 64'd2);
      end
      chk("wrap_last_out0", bus.out0_data, 64'h2026);
      chk("wrap_last_out1", bus.out1_data, 64'h2027);

      // Build count 6, then flush while pushing and popping
      drive(1, 64'h30, 1, 64'h31, 0, 0, 0);
      step();
      drive(1, 64'h32, 1, 64'h33, 0, 0, 0);
      step();
      chk("preflush_count", 64'(bus.count), 64'd6);
      drive(1, 64'h40, 1, 64'h41, 1, 1, 1);
      step();
      chk("flush_count", 64'(bus.count), 64'd0);
      chk("flush_out0_valid", 64'(bus.out0_valid), 64'd0);
      chk("flush_out1_valid", 64'(bus.out1_valid), 64'd0);

      // Refill, then assert reset between edges
      drive(1, 64'h50, 1, 64'h51, 0, 0, 0);
      step();
      chk("refill_out0", bus.out0_data, 64'h50);
      drive(0, '0, 0, '0, 0, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_count", 64'(bus.count), 64'd0);
      chk("async_rst_out0_valid", 64'(bus.out0_valid), 64'd0);
      chk("async_rst_out1_valid", 64'(bus.out1_valid), 64'd0);
      chk("async_rst_pause", 64'(bus.pause_req), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
